// File: rtl/sm4_pkg.sv
// Shared SM4 constants, FSM state encoding and a rotate helper.
package sm4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEXP  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] FK [4] = '{
    32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
  };

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  function automatic logic [31:0] rotl32(input logic [31:0] b, input int unsigned n);
    return (b << n) | (b >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_dec_core_if.sv
// Block-in / block-out handshake bundle of the SM4 decryption core.
interface sm4_dec_core_if;
  logic         din_valid;
  logic         din_ready;
  logic [127:0] key;
  logic [127:0] din;
  logic         dout_valid;
  logic         dout_ready;
  logic [127:0] dout;
  logic         busy;

  modport master (
    output din_valid, key, din, dout_ready,
    input  din_ready, dout_valid, dout, busy
  );

  modport slave (
    input  din_valid, key, din, dout_ready,
    output din_ready, dout_valid, dout, busy
  );
endinterface

// File: rtl/sm4_sbox.sv
// SM4 8-bit S-box, pure combinational lookup.
module sm4_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] b_o
);
  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  assign b_o = SBOX[a_i];
endmodule

// File: rtl/sm4_dec_core.sv
// Iterative SM4 block decryptor: 32-cycle key expansion (skipped on a
// cached key), 32 decryption rounds, result held until consumed.
module sm4_dec_core #(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  sm4_dec_core_if.slave  bus
);
  import sm4_pkg::*;

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         cache_valid_q, cache_valid_d;
  logic         dout_valid_q, dout_valid_d;
  logic         din_ready_q, busy_q;
  logic [127:0] dout_q;

  logic [127:0] key_q;
  logic [31:0]  x_q [4];
  logic [31:0]  k_q [4];
  logic [31:0]  rk_q [32];

  logic         accept, hit, last;
  logic [31:0]  rin, rtau, x_new;
  logic [31:0]  kin, ktau, rk_new;

  function automatic logic [31:0] l_round(input logic [31:0] b);
    return b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rotl32(b, 13) ^ rotl32(b, 23);
  endfunction

  assign accept = bus.din_valid & din_ready_q;
  assign hit    = KEY_CACHE && cache_valid_q && (bus.key == key_q);
  assign last   = (cnt_q == 5'd31);

  // Decryption consumes round keys in reverse order.
  assign rin    = x_q[1] ^ x_q[2] ^ x_q[3] ^ rk_q[~cnt_q];
  assign x_new  = x_q[0] ^ l_round(rtau);
  assign kin    = k_q[1] ^ k_q[2] ^ k_q[3] ^ CK[cnt_q];
  assign rk_new = k_q[0] ^ l_key(ktau);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_round_sbox (.a_i(rin[8*g +: 8]), .b_o(rtau[8*g +: 8]));
    sm4_sbox u_key_sbox   (.a_i(kin[8*g +: 8]), .b_o(ktau[8*g +: 8]));
  end

  // Next-state, counter and control-flag decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cache_valid_d = cache_valid_q;
    dout_valid_d  = dout_valid_q;
    case (state_q)
      IDLE: begin
        cnt_d = 5'd0;
        if (accept) begin
          if (hit) begin
            state_d = ROUND;
          end else begin
            state_d       = KEXP;
            cache_valid_d = 1'b0;
          end
        end
      end
      KEXP: begin
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          state_d       = ROUND;
          cache_valid_d = 1'b1;
        end
      end
      ROUND: begin
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          state_d      = DONE;
          dout_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.dout_ready) begin
          state_d      = IDLE;
          dout_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; ready/busy are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 5'd0;
      cache_valid_q <= 1'b0;
      dout_valid_q  <= 1'b0;
      din_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cache_valid_q <= cache_valid_d;
      dout_valid_q  <= dout_valid_d;
      din_ready_q   <= (state_d == IDLE);
      busy_q        <= (state_d != IDLE);
    end
  end

  // Plaintext register, loaded with {X35,X34,X33,X32} on the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (state_q == ROUND && last) begin
      dout_q <= {x_new, x_q[3], x_q[2], x_q[1]};
    end
  end

  // Datapath: block/key capture, key schedule and round shift registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_q <= bus.key;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= bus.din[127-32*i -: 32];
        k_q[i] <= bus.key[127-32*i -: 32] ^ FK[i];
      end
    end else if (state_q == KEXP) begin
      rk_q[cnt_q] <= rk_new;
      k_q[0]      <= k_q[1];
      k_q[1]      <= k_q[2];
      k_q[2]      <= k_q[3];
      k_q[3]      <= rk_new;
    end else if (state_q == ROUND) begin
      x_q[0] <= x_q[1];
      x_q[1] <= x_q[2];
      x_q[2] <= x_q[3];
      x_q[3] <= x_new;
    end
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.busy       = busy_q;

endmodule
